// File: rtl/spi_master_driver.sv
// SPI master engine.
// Takes bytes on a valid/ready stream and shifts them out MSB-first in any of
// the four SPI modes. Each received MISO byte comes back with a one-cycle
// rx_valid strobe. The engine owns cs_n framing: tx_last closes the burst.
// All bus outputs are registered, so sclk/mosi/cs_n are glitch-free.
module spi_master_driver #(
  parameter int unsigned CLK_DIV  = 4,  // sclk half-period in adc_clk cycles
  parameter int unsigned CS_SETUP = 2,  // cs_n fall to first sclk edge
  parameter int unsigned CS_HOLD  = 2,  // last sclk edge to cs_n rise
  parameter int unsigned CS_IDLE  = 2   // minimum cs_n high time between bursts
) (
  input  logic       adc_clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    NEXT,
    HOLD,
    GAP
  } state_t;

  // Terminal values of the shared cycle counter for each timed phase.
  localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
  localparam logic [15:0] DIV_END   = 16'(CLK_DIV - 1);
  localparam logic [15:0] HOLD_END  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_END   = 16'(CS_IDLE - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;          // cycles spent in the current phase
  logic [4:0]  edge_reg, edge_next;        // sclk edges already issued in this byte
  logic [7:0]  tx_shift_reg, tx_shift_next;
  logic [6:0]  rx_shift_reg, rx_shift_next;
  logic        last_reg, last_next;
  logic        cpol_reg, cpol_next;
  logic        cpha_reg, cpha_next;
  logic        sclk_reg, sclk_next;
  logic        mosi_reg, mosi_next;
  logic        cs_n_reg, cs_n_next;
  logic        busy_reg, busy_next;
  logic [7:0]  rx_data_reg, rx_data_next;
  logic        rx_valid_reg, rx_valid_next;

  // Edge bookkeeping decoded inside the next-state logic.
  logic        do_edge;
  logic        leading;
  logic        sample_edge;
  logic        final_sample;

  // State register.
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, bus timing and shift datapath.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    edge_next     = edge_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    last_next     = last_reg;
    cpol_next     = cpol_reg;
    cpha_next     = cpha_reg;
    sclk_next     = sclk_reg;
    mosi_next     = mosi_reg;
    cs_n_next     = cs_n_reg;
    busy_next     = busy_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    tx_ready      = 1'b0;
    do_edge       = 1'b0;
    leading       = 1'b0;
    sample_edge   = 1'b0;
    final_sample  = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_ready  = 1'b1;
        // Idle clock level tracks the live mode so the bus is parked
        // correctly before cs_n ever falls.
        sclk_next = mode[1];
        if (tx_valid) begin
          tx_shift_next = tx_data;
          last_next     = tx_last;
          cpol_next     = mode[1];
          cpha_next     = mode[0];
          // CPHA=0 slaves sample on the first edge, so bit7 must already
          // be on the wire while cs_n settles.
          if (!mode[0]) begin
            mosi_next = tx_data[7];
          end
          cs_n_next  = 1'b0;
          busy_next  = 1'b1;
          cnt_next   = '0;
          edge_next  = '0;
          state_next = SETUP;
        end
      end

      SETUP: begin
        // The first sclk edge is issued on the cycle that ends setup.
        if (cnt_reg == SETUP_END) begin
          do_edge    = 1'b1;
          cnt_next   = '0;
          state_next = SHIFT;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      SHIFT: begin
        if (cnt_reg == DIV_END) begin
          do_edge  = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      NEXT: begin
        tx_ready  = 1'b1;
        sclk_next = cpol_reg;
        // With no new byte the burst simply stalls here with cs_n low.
        if (tx_valid) begin
          tx_shift_next = tx_data;
          last_next     = tx_last;
          if (!cpha_reg) begin
            mosi_next = tx_data[7];
          end
          // Restarting SHIFT from zero gives one half-period of spacing
          // before the first edge of the new byte.
          cnt_next   = '0;
          edge_next  = '0;
          state_next = SHIFT;
        end
      end

      HOLD: begin
        sclk_next = cpol_reg;
        if (cnt_reg == HOLD_END) begin
          cs_n_next  = 1'b1;
          cnt_next   = '0;
          state_next = GAP;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      GAP: begin
        sclk_next = cpol_reg;
        if (cnt_reg == GAP_END) begin
          busy_next  = 1'b0;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (do_edge) begin
      sclk_next = ~sclk_reg;
      edge_next = edge_reg + 5'd1;
      // edge_reg counts edges already done, so an even count means the
      // upcoming edge is odd, i.e. the leading edge of a bit.
      leading      = ~edge_reg[0];
      sample_edge  = (leading != cpha_reg);
      // CPHA=0 takes its last sample on edge 15, CPHA=1 on edge 16.
      final_sample = cpha_reg ? (edge_reg == 5'd15) : (edge_reg == 5'd14);

      if (sample_edge) begin
        rx_shift_next = {rx_shift_reg[5:0], miso};
        if (final_sample) begin
          rx_data_next  = {rx_shift_reg, miso};
          rx_valid_next = 1'b1;
        end
      end else if (cpha_reg) begin
        // CPHA=1: present the next bit on each leading edge, bit7 first.
        mosi_next     = tx_shift_reg[7];
        tx_shift_next = {tx_shift_reg[6:0], 1'b0};
      end else if (edge_reg != 5'd15) begin
        // CPHA=0: bit7 is already out, so trailing edges advance to the next
        // bit; the closing edge leaves the last bit on the wire.
        mosi_next     = tx_shift_reg[6];
        tx_shift_next = {tx_shift_reg[6:0], 1'b0};
      end

      if (edge_reg == 5'd15) begin
        cnt_next   = '0;
        state_next = last_reg ? HOLD : NEXT;
      end
    end
  end

  // Datapath and bus output registers.
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      edge_reg     <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      last_reg     <= 1'b0;
      cpol_reg     <= 1'b0;
      cpha_reg     <= 1'b0;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      cs_n_reg     <= 1'b1;
      busy_reg     <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      edge_reg     <= edge_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      last_reg     <= last_next;
      cpol_reg     <= cpol_next;
      cpha_reg     <= cpha_next;
      sclk_reg     <= sclk_next;
      mosi_reg     <= mosi_next;
      cs_n_reg     <= cs_n_next;
      busy_reg     <= busy_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
    end
  end

  assign sclk     = sclk_reg;
  assign mosi     = mosi_reg;
  assign cs_n     = cs_n_reg;
  assign busy     = busy_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_master_driver.sv
// Bench for spi_master_driver: directed transactions against a behavioural
// SPI slave. Expected rx bytes and expected slave-received bytes are queued
// when stimulus is issued and popped by independent monitors.
module tb_spi_master_driver;

  localparam int LIM = 2000;

  logic       adc_clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;

  logic       slave_miso = 1'b0;
  logic       loopback = 1'b0;
  logic [1:0] s_mode = 2'd0;

  int checks = 0;
  int errors = 0;
  int rx_count = 0;
  int cs_falls = 0;
  int sclk_edges = 0;

  logic [7:0] rx_exp[$];   // bytes the master should return on rx_data
  logic [7:0] sl_exp[$];   // bytes the slave should see on mosi
  logic [7:0] s_resp[$];   // bytes the slave will drive on miso

  assign miso = loopback ? mosi : slave_miso;

  spi_master_driver #(
    .CLK_DIV (4),
    .CS_SETUP(2),
    .CS_HOLD (2),
    .CS_IDLE (2)
  ) dut (
    .adc_clk (adc_clk),
    .rst     (rst),
    .mode    (mode),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_last (tx_last),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Present one byte and hold it until the engine accepts it.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    @(negedge adc_clk);
    tx_data  = d;
    tx_valid = 1'b1;
    tx_last  = l;
    n = 0;
    while (!tx_ready && n < LIM) begin
      @(negedge adc_clk);
      n++;
    end
    if (n >= LIM) begin
      fail_now("accept_timeout");
      tx_valid = 1'b0;
    end else begin
      @(posedge adc_clk);
      #1;
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge adc_clk);
    while (busy && n < LIM) begin
      @(negedge adc_clk);
      n++;
    end
    if (n >= LIM) fail_now(name);
    @(negedge adc_clk);
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge adc_clk);
    mode   = m;
    s_mode = m;
    repeat (3) @(negedge adc_clk);
  endtask

  // rx scoreboard monitor plus bus event counters.
  initial begin
    logic rxv_prev;
    logic sclk_prev;
    logic cs_prev;
    rxv_prev  = 1'b0;
    sclk_prev = 1'b0;
    cs_prev   = 1'b1;
    forever begin
      @(posedge adc_clk);
      #1;
      if (cs_prev && !cs_n) cs_falls++;
      if (sclk !== sclk_prev) sclk_edges++;
      if (rx_valid) begin
        rx_count++;
        $display("rx byte 0x%02h", rx_data);
        check("rx_valid_width", {31'd0, rxv_prev}, 32'd0);
        if (rx_exp.size() == 0) begin
          fail_now("rx_unexpected");
        end else begin
          check("rx_data", {24'd0, rx_data}, {24'd0, rx_exp.pop_front()});
        end
      end
      rxv_prev  = rx_valid;
      sclk_prev = sclk;
      cs_prev   = cs_n;
    end
  end

  // Behavioural SPI slave, evaluated on the falling adc_clk edge so it sees
  // settled master outputs.
  initial begin
    logic       s_active;
    logic       s_prev;
    logic       lead;
    logic [7:0] s_tx;
    logic [7:0] s_rx;
    int         s_bits;
    int         s_dcnt;
    s_active = 1'b0;
    s_prev   = 1'b0;
    s_tx     = 8'h00;
    s_rx     = 8'h00;
    s_bits   = 0;
    s_dcnt   = 0;
    forever begin
      @(negedge adc_clk);
      if (rst || cs_n) begin
        s_active = 1'b0;
        s_bits   = 0;
        s_dcnt   = 0;
        s_prev   = sclk;
      end else if (!s_active) begin
        s_active = 1'b1;
        s_prev   = sclk;
        if (!s_mode[0]) begin
          s_tx       = (s_resp.size() > 0) ? s_resp.pop_front() : 8'h00;
          slave_miso = s_tx[7];
          s_tx       = {s_tx[6:0], 1'b0};
          s_dcnt     = 1;
        end
      end else if (sclk !== s_prev) begin
        s_prev = sclk;
        lead   = (sclk != s_mode[1]);
        if (lead != s_mode[0]) begin
          s_rx = {s_rx[6:0], mosi};
          s_bits++;
          if (s_bits == 8) begin
            s_bits = 0;
            $display("slave rec 0x%02h", s_rx);
            if (sl_exp.size() == 0) fail_now("slave_unexpected");
            else check("slave_rec", {24'd0, s_rx}, {24'd0, sl_exp.pop_front()});
          end
        end else begin
          if (s_dcnt == 0) s_tx = (s_resp.size() > 0) ? s_resp.pop_front() : 8'h00;
          slave_miso = s_tx[7];
          s_tx       = {s_tx[6:0], 1'b0};
          s_dcnt     = (s_dcnt == 7) ? 0 : s_dcnt + 1;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int c, n, rises, nedges, first_rise, prev_rise, last_edge, cs_rise, spacing_err;
    int snap_edges, snap_falls, stall_bad, idx;
    logic       prev_sclk;
    logic [7:0] mosi_byte;
    logic [7:0] t6_b[3];
    logic       t6_l[3];

    // Reset state while rst is held.
    repeat (3) @(negedge adc_clk);
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    rst = 1'b0;
    set_mode(2'd0);

    // Mode 0 single byte 0xA5, slave answers 0x3C; timing measured inline.
    sl_exp.push_back(8'hA5);
    s_resp.push_back(8'h3C);
    rx_exp.push_back(8'h3C);
    @(negedge adc_clk);
    tx_data = 8'hA5; tx_valid = 1'b1; tx_last = 1'b1;
    @(posedge adc_clk);
    #1;
    tx_valid = 1'b0;
    c = 0; rises = 0; nedges = 0; first_rise = -1; prev_rise = 0;
    last_edge = -1; cs_rise = -1; spacing_err = 0; mosi_byte = 8'h00;
    prev_sclk = sclk;
    check("t1_cs_low_at_accept", {31'd0, cs_n}, 32'd0);
    while (busy && c < 400) begin
      @(posedge adc_clk);
      #1;
      c++;
      if (sclk !== prev_sclk) begin
        nedges++;
        last_edge = c;
        if (sclk) begin
          rises++;
          if (rises == 1) first_rise = c;
          else if (c - prev_rise != 8) spacing_err++;
          prev_rise = c;
          mosi_byte = {mosi_byte[6:0], mosi};
        end
        prev_sclk = sclk;
      end
      if (cs_n && cs_rise < 0) cs_rise = c;
    end
    check("t1_first_rise", first_rise, 32'd2);
    check("t1_rises", rises, 32'd8);
    check("t1_edges", nedges, 32'd16);
    check("t1_rise_spacing_errs", spacing_err, 32'd0);
    check("t1_mosi_bits", {24'd0, mosi_byte}, 32'hA5);
    check("t1_last_edge", last_edge, 32'd62);
    check("t1_cs_rise", cs_rise, 32'd64);
    check("t1_busy_fall", c, 32'd66);
    check("t1_mosi_holds", {31'd0, mosi}, 32'd1);
    wait_idle("t1_idle");

    // Mode 3 burst in loopback: one cs_n window, bytes echoed back.
    set_mode(2'd3);
    check("t2_sclk_idle_high", {31'd0, sclk}, 32'd1);
    loopback = 1'b1;
    snap_falls = cs_falls;
    sl_exp.push_back(8'h01); sl_exp.push_back(8'h80); sl_exp.push_back(8'hFF);
    rx_exp.push_back(8'h01); rx_exp.push_back(8'h80); rx_exp.push_back(8'hFF);
    send_byte(8'h01, 1'b0);
    send_byte(8'h80, 1'b0);
    send_byte(8'hFF, 1'b1);
    wait_idle("t2_idle");
    check("t2_cs_windows", cs_falls - snap_falls, 32'd1);
    loopback = 1'b0;

    // Mode 0 burst with a 20-cycle stall in NEXT.
    set_mode(2'd0);
    snap_falls = cs_falls;
    sl_exp.push_back(8'hDE); sl_exp.push_back(8'hAD);
    s_resp.push_back(8'hBE); s_resp.push_back(8'hEF);
    rx_exp.push_back(8'hBE); rx_exp.push_back(8'hEF);
    send_byte(8'hDE, 1'b0);
    n = 0;
    @(negedge adc_clk);
    while (!tx_ready && n < LIM) begin
      @(negedge adc_clk);
      n++;
    end
    if (n >= LIM) fail_now("t3_next_timeout");
    snap_edges = sclk_edges;
    stall_bad = 0;
    repeat (20) begin
      @(negedge adc_clk);
      if (cs_n !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1) stall_bad++;
    end
    check("t3_stall_bus", stall_bad, 32'd0);
    check("t3_stall_no_edges", sclk_edges - snap_edges, 32'd0);
    send_byte(8'hAD, 1'b1);
    wait_idle("t3_idle");
    check("t3_cs_windows", cs_falls - snap_falls, 32'd1);

    // Modes 1 and 2 against the slave model.
    set_mode(2'd1);
    sl_exp.push_back(8'hC3); s_resp.push_back(8'h96); rx_exp.push_back(8'h96);
    send_byte(8'hC3, 1'b1);
    wait_idle("t4_m1_idle");
    set_mode(2'd2);
    check("t4_sclk_idle_high", {31'd0, sclk}, 32'd1);
    sl_exp.push_back(8'hC3); s_resp.push_back(8'h69); rx_exp.push_back(8'h69);
    send_byte(8'hC3, 1'b1);
    wait_idle("t4_m2_idle");

    // Reset at edge 7 of 0x5A: bus returns to reset values at once.
    set_mode(2'd0);
    s_resp.push_back(8'hE7);
    send_byte(8'h5A, 1'b1);
    n = 0; c = 0; prev_sclk = sclk;
    while (c < 7 && n < 200) begin
      @(posedge adc_clk);
      #1;
      n++;
      if (sclk !== prev_sclk) begin
        c++;
        prev_sclk = sclk;
      end
    end
    if (n >= 200) fail_now("t5_edge7_timeout");
    rst = 1'b1;
    #1;
    check("t5_rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("t5_rst_sclk", {31'd0, sclk}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    repeat (3) @(negedge adc_clk);
    rst = 1'b0;
    repeat (3) @(negedge adc_clk);
    sl_exp.push_back(8'h5A); s_resp.push_back(8'h81); rx_exp.push_back(8'h81);
    send_byte(8'h5A, 1'b1);
    wait_idle("t5_idle");

    // tx_valid held high with junk data whenever tx_ready is low.
    set_mode(2'd1);
    t6_b[0] = 8'h12; t6_b[1] = 8'h34; t6_b[2] = 8'h56;
    t6_l[0] = 1'b0;  t6_l[1] = 1'b1;  t6_l[2] = 1'b1;
    sl_exp.push_back(8'h12); sl_exp.push_back(8'h34); sl_exp.push_back(8'h56);
    s_resp.push_back(8'h21); s_resp.push_back(8'h43); s_resp.push_back(8'h65);
    rx_exp.push_back(8'h21); rx_exp.push_back(8'h43); rx_exp.push_back(8'h65);
    idx = 0; n = 0;
    @(negedge adc_clk);
    tx_valid = 1'b1;
    while (idx < 3 && n < LIM) begin
      if (tx_ready) begin
        tx_data = t6_b[idx];
        tx_last = t6_l[idx];
        idx++;
      end else begin
        tx_data = 8'($urandom);
        tx_last = 1'($urandom);
      end
      @(negedge adc_clk);
      n++;
    end
    tx_valid = 1'b0;
    if (n >= LIM) fail_now("t6_timeout");
    wait_idle("t6_idle");

    repeat (10) @(negedge adc_clk);
    check("rx_data_held", {24'd0, rx_data}, 32'h65);
    check("rx_total", rx_count, 32'd12);
    check("rx_queue_empty", rx_exp.size(), 32'd0);
    check("slave_queue_empty", sl_exp.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
